// File: rtl/rr_arb4_enc_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM states,
// requester count/index width and the rotating first-set search.
package rr_arb4_enc_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Returns {found, index} of the first set bit searching ptr, ptr+1, ... mod 4.
  function automatic logic [IDX_W:0] first_set(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ptr + k[IDX_W-1:0];
      if (!res[IDX_W] && req[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb4_enc_encoder4to2.sv
// 4-to-2 binary encoder; input is guaranteed one-hot or zero, zero encodes to 0.
module encoder4to2 (
  input  logic [3:0] onehot,
  output logic [1:0] idx
);

  assign idx = {onehot[3] | onehot[2], onehot[3] | onehot[1]};

endmodule

// File: rtl/rr_arb4_enc.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// encoded grant index and a per-owner hold quota.
module rr_arb4_enc
  import rr_arb4_enc_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       gnt_idx,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  state_t                 state, state_nxt;
  logic [NUM_REQ-1:0]     gnt_nxt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [IDX_W-1:0]       ptr, ptr_nxt;
  logic [IDX_W:0]         search;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      hold_cnt <= '0;
      ptr      <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      hold_cnt <= cnt_nxt;
      ptr      <= ptr_nxt;
    end
  end

  // The registered grant index doubles as the current owner.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    cnt_nxt   = hold_cnt;
    ptr_nxt   = ptr;
    search    = first_set(req, ptr);
    unique case (state)
      ST_IDLE: begin
        gnt_nxt = '0;
        cnt_nxt = '0;
        if (en && search[IDX_W]) begin
          gnt_nxt   = NUM_REQ'(1) << search[IDX_W-1:0];
          cnt_nxt   = ONE_C;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (req[gnt_idx] && (hold_cnt < MAX_HOLD_C)) begin
          cnt_nxt = hold_cnt + ONE_C;
        end else begin
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          ptr_nxt   = gnt_idx + IDX_W'(1);
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  encoder4to2 u_enc (
    .onehot (gnt),
    .idx    (gnt_idx)
  );

  assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Self-checking bench: four arbiters with different hold quotas share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_rr_arb4_enc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt [4];
  logic [1:0] idx [4];
  logic       vld [4];
  logic [7:0] cnt [4];

  int total = 0;
  int bad   = 0;

  // Model state: owner (-1 when idle), cycles held, priority pointer.
  int mh    [4] = '{8, 2, 3, 1};
  int m_own [4];
  int m_cnt [4];
  int m_ptr [4];

  always #5 clk = ~clk;

  rr_arb4_enc #(.MAX_HOLD(8), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt[0]), .gnt_idx(idx[0]), .gnt_valid(vld[0]), .hold_cnt(cnt[0]));
  rr_arb4_enc #(.MAX_HOLD(2), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt[1]), .gnt_idx(idx[1]), .gnt_valid(vld[1]), .hold_cnt(cnt[1]));
  rr_arb4_enc #(.MAX_HOLD(3), .CNT_W(8)) u2 (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt[2]), .gnt_idx(idx[2]), .gnt_valid(vld[2]), .hold_cnt(cnt[2]));
  rr_arb4_enc #(.MAX_HOLD(1), .CNT_W(8)) u3 (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt[3]), .gnt_idx(idx[3]), .gnt_valid(vld[3]), .hold_cnt(cnt[3]));

  function automatic logic [14:0] act_of(input int i);
    return {gnt[i], idx[i], vld[i], cnt[i]};
  endfunction

  function automatic logic [14:0] exp_of(input int i);
    logic [3:0] g;
    logic [1:0] x;
    g = 4'b0000;
    x = 2'd0;
    if (m_own[i] >= 0) begin
      g = 4'b0001 << m_own[i];
      x = 2'(m_own[i]);
    end
    return {g, x, (m_own[i] >= 0), 8'(m_cnt[i])};
  endfunction

  // Advance one clock: apply the arbitration rules to the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_own[i] = -1; m_cnt[i] = 0; m_ptr[i] = 0;
      end else if (m_own[i] < 0) begin
        if (en && req != 4'b0000) begin
          for (int k = 0; k < 4; k++) begin
            if (m_own[i] < 0 && req[(m_ptr[i] + k) % 4]) begin
              m_own[i] = (m_ptr[i] + k) % 4;
              m_cnt[i] = 1;
            end
          end
        end
      end else if (req[m_own[i]] && m_cnt[i] < mh[i]) begin
        m_cnt[i] = m_cnt[i] + 1;
      end else begin
        m_ptr[i] = (m_own[i] + 1) % 4;
        m_own[i] = -1;
        m_cnt[i] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        total++;
        if (act_of(i) !== 15'd0) begin
          bad++;
          $display("FAIL reset u%0d: got %h want 0", i, act_of(i));
        end
      end
    end
  endtask

  task automatic test_single();
    rst_n = 1'b1; en = 1'b1; req = 4'b0100;
    tick();
    total++;
    if (gnt[0] !== 4'b0100 || idx[0] !== 2'd2 || cnt[0] !== 8'd1) begin
      bad++;
      $display("FAIL single_first: got gnt=%b idx=%0d cnt=%0d want 0100/2/1", gnt[0], idx[0], cnt[0]);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        total++;
        if (act_of(i) !== exp_of(i)) begin
          bad++;
          $display("FAIL single u%0d c%0d: got %h want %h", i, c, act_of(i), exp_of(i));
        end
      end
    end
    total++;
    if (cnt[0] !== 8'd6) begin
      bad++;
      $display("FAIL single_count: got %0d want 6", cnt[0]);
    end
    req = 4'b0000;
    tick();
    total++;
    if (gnt[0] !== 4'b0000 || vld[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_release: got gnt=%b vld=%b want 0000/0", gnt[0], vld[0]);
    end
    // ptr is now 3, so requester 3 beats requester 0.
    req = 4'b1001;
    tick();
    total++;
    if (gnt[0] !== 4'b1000 || idx[0] !== 2'd3) begin
      bad++;
      $display("FAIL single_ptr: got gnt=%b idx=%0d want 1000/3", gnt[0], idx[0]);
    end
  endtask

  task automatic test_round_robin();
    int order [$];
    int want  [5] = '{0, 1, 2, 3, 0};
    logic prev_vld;
    rst_n = 1'b0; req = 4'b1111; en = 1'b1;
    tick();
    rst_n = 1'b1;
    prev_vld = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (vld[1] && !prev_vld) order.push_back(int'(idx[1]));
      prev_vld = vld[1];
      for (int i = 0; i < 4; i++) begin
        total++;
        if (act_of(i) !== exp_of(i)) begin
          bad++;
          $display("FAIL rr u%0d c%0d: got %h want %h", i, c, act_of(i), exp_of(i));
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (k >= order.size() || order[k] !== want[k]) begin
        bad++;
        $display("FAIL rr_order k%0d: got %0d want %0d", k, (k < order.size()) ? order[k] : -1, want[k]);
      end
    end
  endtask

  task automatic test_quota();
    int on_cycles;
    rst_n = 1'b0; req = 4'b0001; en = 1'b1;
    tick();
    rst_n = 1'b1;
    on_cycles = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (gnt[2] === 4'b0001) on_cycles++;
      total++;
      if (cnt[2] > 8'd3 || act_of(2) !== exp_of(2)) begin
        bad++;
        $display("FAIL quota c%0d: got %h want %h", c, act_of(2), exp_of(2));
      end
    end
    // Pattern 3 on, 1 off over 12 cycles.
    total++;
    if (on_cycles != 9) begin
      bad++;
      $display("FAIL quota_duty: got %0d want 9", on_cycles);
    end
  endtask

  task automatic test_en_gating();
    rst_n = 1'b0; req = 4'b0010; en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (gnt[0] !== 4'b0010) begin
        bad++;
        $display("FAIL en_hold c%0d: got %b want 0010", c, gnt[0]);
      end
    end
    req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (gnt[0] !== 4'b0000 || act_of(1) !== exp_of(1)) begin
        bad++;
        $display("FAIL en_block c%0d: got %b want 0000", c, gnt[0]);
      end
    end
    en = 1'b1;
    tick();
    total++;
    if (gnt[0] !== 4'b1000 || idx[0] !== 2'd3) begin
      bad++;
      $display("FAIL en_resume: got gnt=%b idx=%0d want 1000/3", gnt[0], idx[0]);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; req = 4'b1000; en = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    total++;
    if (gnt[0] !== 4'b1000 || cnt[0] !== 8'd5) begin
      bad++;
      $display("FAIL mid_setup: got gnt=%b cnt=%0d want 1000/5", gnt[0], cnt[0]);
    end
    rst_n = 1'b0; req = 4'b1010;
    tick();
    total++;
    if (act_of(0) !== 15'd0) begin
      bad++;
      $display("FAIL mid_reset: got %h want 0", act_of(0));
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (gnt[0] !== 4'b0010 || idx[0] !== 2'd1 || cnt[0] !== 8'd1) begin
      bad++;
      $display("FAIL mid_regrant: got gnt=%b idx=%0d cnt=%0d want 0010/1/1", gnt[0], idx[0], cnt[0]);
    end
  endtask

  task automatic test_churn();
    rst_n = 1'b0; req = 4'b0001; en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      req = {3'($urandom), 1'b1};
      tick();
      total++;
      if (gnt[0] !== 4'b0001 || idx[0] !== 2'd0 || act_of(0) !== exp_of(0)) begin
        bad++;
        $display("FAIL churn c%0d: got gnt=%b idx=%0d want 0001/0", c, gnt[0], idx[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      en    = ($urandom_range(0, 3) != 0);
      req   = 4'($urandom);
      tick();
      for (int i = 0; i < 4; i++) begin
        total++;
        if (act_of(i) !== exp_of(i)) begin
          bad++;
          $display("FAIL random u%0d c%0d: got %h want %h", i, c, act_of(i), exp_of(i));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_own[i] = -1; m_cnt[i] = 0; m_ptr[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_quota();
    test_en_gating();
    test_reset_mid();
    test_churn();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
